// File: rtl/led_fade_pkg.sv
// Shared constants, level-update opcode and helpers for the LED fade/PWM block.
package led_fade_pkg;

    localparam int unsigned DEF_PWM_BITS   = 8;
    localparam logic [23:0] DEF_DECAY_DIV  = 24'd65536;
    localparam int unsigned DEF_DECAY_STEP = 16;

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_LOAD,
        LVL_DECAY
    } lvl_op_e;

    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with tick-driven decay and registered PWM compare.
// Brightness curve is quadratic when LED_FADE_GAMMA_EN is defined, linear otherwise.
module led_pwm_channel
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
    parameter int unsigned DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_in,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;
    logic [PWM_BITS-1:0] eff;
    logic                pwm_nxt;
    lvl_op_e             op;

    // A lit input always wins over a concurrent decay tick.
    always_comb begin
        op = LVL_HOLD;
        if (data_in) begin
            op = LVL_LOAD;
        end else if (tick) begin
            op = LVL_DECAY;
        end
    end

    always_comb begin
        level_nxt = level;
        case (op)
            LVL_LOAD:  level_nxt = MAX;
            LVL_DECAY: level_nxt = (level < STEP) ? '0 : (level - STEP);
            default:   level_nxt = level;
        endcase
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_ext;
    logic [2*PWM_BITS-1:0] level_sq;

    always_comb begin
        level_ext = (2*PWM_BITS)'(level);
        level_sq  = level_ext * level_ext;
        eff       = level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        eff = level;
    end
`endif

    // Full and zero levels bypass the compare so the ends stay solid on/off.
    always_comb begin
        if (level == MAX) begin
            pwm_nxt = 1'b1;
        end else if (level == '0) begin
            pwm_nxt = 1'b0;
        end else begin
            pwm_nxt = (eff > pwm_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            pwm_out <= 1'b0;
        end else begin
            level   <= level_nxt;
            pwm_out <= pwm_nxt;
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade PWM top: shared decay prescaler and PWM counter feeding per-LED channels.
// Optional quadratic brightness curve enabled by defining LED_FADE_GAMMA_EN.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int unsigned LED_WIDTH  = 8,
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
    parameter logic [23:0] DECAY_DIV  = DEF_DECAY_DIV,
    parameter int unsigned DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LED_WIDTH-1:0] led_data_in,
    output logic [LED_WIDTH-1:0] led_pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX        = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CNT_LAST   = MAX - PWM_BITS'(1);
    localparam logic [23:0]         PRESC_LAST = DECAY_DIV - 24'd1;

    logic [23:0]         presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;

    // With DECAY_DIV == 1 the prescaler sits at 0 and tick stays high.
    always_comb begin
        tick = (presc == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == CNT_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < int'(LED_WIDTH); i++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_in (led_data_in[i]),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .pwm_out (led_pwm_out[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: three instances with different decay settings
// checked every clock against an arithmetic model of levels, ticks and PWM phase.
module tb_led_fade_pwm;

    localparam int A_DIV  = 4;
    localparam int A_STEP = 64;
    localparam int B_DIV  = 3;
    localparam int B_STEP = 100;
    localparam int C_DIV  = 300;
`ifdef LED_FADE_GAMMA_EN
    localparam int C_STEP = 127;
`else
    localparam int C_STEP = 128;
`endif
    localparam int MAXV  = 255;
    localparam int L_MID = MAXV - C_STEP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_a, data_b, data_c;
    logic [7:0] out_a, out_b, out_c;
    logic [7:0] lv_a [8];
    logic [7:0] lv_b [8];
    logic [7:0] lv_c [8];

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release and per-channel level.
    int lvl [3][8];
    int cyc;
    int div_p [3];
    int step_p [3];

    int exp_dec_a [5] = '{255, 191, 127, 63, 0};
    int exp_dec_b [4] = '{255, 155, 55, 0};
    int qa [$];
    int qb [$];
    int found;
    int cnt;

    always #5 clk = ~clk;

    led_fade_pwm #(
        .LED_WIDTH(8), .PWM_BITS(8), .DECAY_DIV(24'(A_DIV)), .DECAY_STEP(A_STEP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .led_data_in(data_a), .led_pwm_out(out_a)
    );

    led_fade_pwm #(
        .LED_WIDTH(8), .PWM_BITS(8), .DECAY_DIV(24'(B_DIV)), .DECAY_STEP(B_STEP)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .led_data_in(data_b), .led_pwm_out(out_b)
    );

    led_fade_pwm #(
        .LED_WIDTH(8), .PWM_BITS(8), .DECAY_DIV(24'(C_DIV)), .DECAY_STEP(C_STEP)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .led_data_in(data_c), .led_pwm_out(out_c)
    );

    for (genvar g = 0; g < 8; g++) begin : g_tap
        assign lv_a[g] = dut_a.g_chan[g].u_chan.level;
        assign lv_b[g] = dut_b.g_chan[g].u_chan.level;
        assign lv_c[g] = dut_c.g_chan[g].u_chan.level;
    end

    function automatic int eff_of(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    function automatic logic drive_of(input int l, input int phase);
        if (l == MAXV) return 1'b1;
        if (l == 0) return 1'b0;
        return (eff_of(l) > phase);
    endfunction

    function automatic logic [63:0] model_lv(input int k);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(lvl[k][i]);
        return v;
    endfunction

    function automatic logic [63:0] obs_lv(input int k);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            case (k)
                0:       v[8*i +: 8] = lv_a[i];
                1:       v[8*i +: 8] = lv_b[i];
                default: v[8*i +: 8] = lv_c[i];
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) lvl[k][i] = 0;
    endtask

    // Drive one clock from a negedge, advance the model, and compare at the next negedge.
    task automatic cycle(input logic [7:0] da, input logic [7:0] db, input logic [7:0] dc);
        logic [7:0] exp_o [3];
        logic [7:0] d;
        logic       t;
        data_a = da;
        data_b = db;
        data_c = dc;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? da : ((k == 1) ? db : dc);
            t = ((cyc % div_p[k]) == (div_p[k] - 1));
            for (int i = 0; i < 8; i++) begin
                exp_o[k][i] = drive_of(lvl[k][i], cyc % MAXV);
                if (d[i]) lvl[k][i] = MAXV;
                else if (t) lvl[k][i] = (lvl[k][i] > step_p[k]) ? (lvl[k][i] - step_p[k]) : 0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("out_a@%0d", cyc), 64'(out_a), 64'(exp_o[0]));
        check($sformatf("out_b@%0d", cyc), 64'(out_b), 64'(exp_o[1]));
        check($sformatf("out_c@%0d", cyc), 64'(out_c), 64'(exp_o[2]));
        check($sformatf("lvl_a@%0d", cyc), obs_lv(0), model_lv(0));
        check($sformatf("lvl_b@%0d", cyc), obs_lv(1), model_lv(1));
        check($sformatf("lvl_c@%0d", cyc), obs_lv(2), model_lv(2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        div_p  = '{A_DIV, B_DIV, C_DIV};
        step_p = '{A_STEP, B_STEP, C_STEP};
        model_reset();

        // Reset held with all inputs lit.
        rst_n  = 1'b0;
        data_a = 8'hFF;
        data_b = 8'hFF;
        data_c = 8'hFF;
        repeat (5) @(negedge clk);
        check("rst_out_a", 64'(out_a), 64'h0);
        check("rst_out_b", 64'(out_b), 64'h0);
        check("rst_out_c", 64'(out_c), 64'h0);
        check("rst_lvl_a", obs_lv(0), 64'h0);
        check("rst_lvl_c", obs_lv(2), 64'h0);

        rst_n = 1'b1;
        cycle(8'hFF, 8'hFF, 8'hFF);
        check("rel_lvl_a", obs_lv(0), {8{8'hFF}});
        check("rel_lvl_b", obs_lv(1), {8{8'hFF}});

        // Decay and saturation staircases on channel 0.
        cycle(8'h01, 8'h01, 8'h00);
        cycle(8'h01, 8'h01, 8'h00);
        qa.delete();
        qb.delete();
        qa.push_back(int'(lv_a[0]));
        qb.push_back(int'(lv_b[0]));
        repeat (24) begin
            cycle(8'h00, 8'h00, 8'h00);
            if (int'(lv_a[0]) != qa[$]) qa.push_back(int'(lv_a[0]));
            if (int'(lv_b[0]) != qb[$]) qb.push_back(int'(lv_b[0]));
        end
        check("decay_a_len", 64'(qa.size()), 64'd5);
        for (int i = 0; i < 5 && i < qa.size(); i++)
            check($sformatf("decay_a[%0d]", i), 64'(qa[i]), 64'(exp_dec_a[i]));
        check("sat_b_len", 64'(qb.size()), 64'd4);
        for (int i = 0; i < 4 && i < qb.size(); i++)
            check($sformatf("sat_b[%0d]", i), 64'(qb[i]), 64'(exp_dec_b[i]));

        // Input rising on the same clock as a tick while level is 63.
        cycle(8'h02, 8'h00, 8'h00);
        found = 0;
        for (int n = 0; n < 64; n++) begin
            if (lvl[0][1] == 63 && (cyc % A_DIV) == (A_DIV - 1)) begin
                found = 1;
                break;
            end
            cycle(8'h00, 8'h00, 8'h00);
        end
        check("prio_reached", 64'(found), 64'd1);
        check("prio_pre_lvl", 64'(lv_a[1]), 64'd63);
        cycle(8'h02, 8'h00, 8'h00);
        check("prio_lvl", 64'(lv_a[1]), 64'd255);

        // Walking one-hot: each channel fades on its own.
        for (int i = 0; i < 8; i++) begin
            cycle(8'(1 << i), 8'(1 << i), 8'(1 << i));
            repeat (6) cycle(8'h00, 8'h00, 8'h00);
        end

        repeat (300) cycle(8'($urandom & $urandom), 8'($urandom & $urandom), 8'($urandom & $urandom));

        // Asynchronous reset in the middle of a fade and PWM period.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_a", 64'(out_a), 64'h0);
        check("mid_rst_out_b", 64'(out_b), 64'h0);
        check("mid_rst_lvl_a", obs_lv(0), 64'h0);
        check("mid_rst_lvl_b", obs_lv(1), 64'h0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (100) cycle(8'($urandom), 8'($urandom & $urandom), 8'($urandom & $urandom));

        // Duty cycle at a stable mid level, at zero and at full on dut_c channel 0.
        cycle(8'h00, 8'h00, 8'h01);
        found = 0;
        for (int n = 0; n < 700; n++) begin
            cycle(8'h00, 8'h00, 8'h00);
            if (lvl[2][0] == L_MID) begin
                found = 1;
                break;
            end
        end
        check("duty_mid_reached", 64'(found), 64'd1);
        cnt = 0;
        repeat (MAXV) begin
            cycle(8'h00, 8'h00, 8'h00);
            cnt += int'(out_c[0]);
        end
        check("duty_mid", 64'(cnt), 64'(eff_of(L_MID)));

        found = 0;
        for (int n = 0; n < 400; n++) begin
            if (lvl[2][0] == 0) begin
                found = 1;
                break;
            end
            cycle(8'h00, 8'h00, 8'h00);
        end
        check("duty_zero_reached", 64'(found), 64'd1);
        cycle(8'h00, 8'h00, 8'h00);
        cnt = 0;
        repeat (MAXV) begin
            cycle(8'h00, 8'h00, 8'h00);
            cnt += int'(out_c[0]);
        end
        check("duty_zero", 64'(cnt), 64'd0);

        cycle(8'h00, 8'h00, 8'h01);
        cnt = 0;
        repeat (MAXV) begin
            cycle(8'h00, 8'h00, 8'h01);
            cnt += int'(out_c[0]);
        end
        check("duty_full", 64'(cnt), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
